// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter,
// sequenced by a BOOT/RUN/HALTED controller with halt > jump > branch > stall priority.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump_taken,
  input  logic        halt_req,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic        br_en;
  logic        jmp_en;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = ifid_q.pc4 + {{14{ifid_q.instr[15]}}, ifid_q.instr[15:0], 2'b00};
  assign jmp_tgt  = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};

  // A redirect from decode only means something if decode holds a real instruction.
  assign jmp_en = jump_taken   & ifid_q.valid;
  assign br_en  = branch_taken & ifid_q.valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        ifid_d  = BUBBLE;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
          ifid_d  = BUBBLE;
        end else if (jmp_en) begin
          pc_d   = jmp_tgt;
          ifid_d = BUBBLE;
        end else if (br_en) begin
          pc_d   = br_tgt;
          ifid_d = BUBBLE;
        end else if (!stall) begin
          pc_d   = pc_plus4;
          ifid_d = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
          cnt_d  = cnt_q + 32'd1;
        end
      end
      HALTED: ;
      default: begin
        state_d = BOOT;
        ifid_d  = BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = ifid_q.instr;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_valid = ifid_q.valid;
  assign opcode      = ifid_q.instr[31:26];
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address loaded into PC on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 imem_addr  output  32  instruction memory address, equal to PC.
REQ-005 imem_rdata  input  32  instruction word, combinational read of imem_addr in same cycle.
REQ-006 stall  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-007 branch_taken  input  1  decode resolved branch taken (Branch & equal).
REQ-008 jump_taken  input  1  decode resolved J/JAL.
REQ-009 halt_req  input  1  stop fetching until reset.
REQ-010 if_id_instr  output  32  registered instruction to decode.
REQ-011 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 opcode  output  6  if_id_instr[31:26], drives decode control input.
REQ-014 halted  output  1  high in HALTED state.
REQ-015 fetch_count  output  32  count of instructions loaded into IF/ID with valid=1.

Function
REQ-016 FSM states: BOOT, RUN, HALTED; BOOT->RUN unconditionally after one cycle; RUN->HALTED when halt_req=1; HALTED exits only via rst.
REQ-017 BOOT: PC holds RESET_PC, IF/ID loaded with bubble, fetch_count unchanged.
REQ-018 Bubble = if_id_instr 32'h0, if_id_pc4 32'h0, if_id_valid 0.
REQ-019 Branch target = if_id_pc4 + (sign-extended if_id_instr[15:0] << 2), 32-bit, wraps modulo 2^32.
REQ-020 Jump target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
REQ-021 RUN priority per cycle: halt_req > jump_taken > branch_taken > stall > normal.
REQ-022 Normal: PC <= PC+4 (wraps modulo 2^32); IF/ID <= {imem_rdata, PC+4, valid 1}; fetch_count +1.
REQ-023 Jump/branch redirect: PC <= target; IF/ID <= bubble (flush of wrong-path fetch); fetch_count unchanged; stall ignored that cycle.
REQ-024 Redirect inputs are honoured only when if_id_valid=1; otherwise treated as 0.
REQ-025 Stall: PC, IF/ID, fetch_count all hold.
REQ-026 halt_req in RUN: PC holds, IF/ID <= bubble, next state HALTED; concurrent redirect/stall ignored.
REQ-027 HALTED: PC, IF/ID (bubble), fetch_count hold; all control inputs ignored.
REQ-028 fetch_count wraps 32'hFFFF_FFFF -> 0.
REQ-029 imem_addr is PC directly; PC[1:0] always 0 (construction guarantees alignment).
REQ-030 opcode and halted are pure functions of registered state; no input-to-output combinational path except none.

Reset
REQ-031 rst=1 at a clock edge: state BOOT, PC=RESET_PC, IF/ID bubble, fetch_count 0, halted 0; overrides all other inputs.
REQ-032 rst asserted mid-stall, mid-redirect or in HALTED gives identical result to REQ-031.

Verification
REQ-033 Reset then 4 free-running cycles, imem returns 32'h8C00_0000+addr -> cycle1 bubble, then IF/ID instr for addr 0,4,8; pc4 4,8,C; fetch_count 3; opcode 6'b100011.
REQ-034 IF/ID holds beq at PC 0x10 with offset 16'hFFFC, branch_taken=1 and stall=1 -> next PC 0x04, IF/ID bubble, fetch_count unchanged.
REQ-035 IF/ID holds j with index 26'h000_0040 at pc4 0x1000_0008 -> next PC 0x1000_0100, IF/ID bubble.
REQ-036 stall held 3 cycles in RUN -> PC, IF/ID, fetch_count constant across all 3; resume advances by exactly 4.
REQ-037 halt_req with jump_taken same cycle -> halted=1, PC unchanged, IF/ID bubble; later stall/branch ignored; rst -> PC=RESET_PC, halted 0.
REQ-038 PC preloaded 32'hFFFF_FFFC via RESET_PC, fetch_count forced near wrap -> PC wraps to 0, fetch_count wraps to 0.
